// File: rtl/rob_pkg.sv
// Shared defaults and types for the reorder-buffer done tracker.
package rob_pkg;

  localparam int ROB_DEPTH    = 32;
  localparam int ROB_NUM_WB   = 7;
  localparam int ROB_COMMIT_W = 2;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

endpackage

// File: rtl/rob_ready_scan.sv
// Counts consecutive ready entries starting at head, capped at COMMIT_W and occupancy.
module rob_ready_scan #(
  parameter  int DEPTH    = 32,
  parameter  int COMMIT_W = 2,
  localparam int IW       = $clog2(DEPTH),
  localparam int CW       = $clog2(COMMIT_W + 1),
  localparam int OW       = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] ready,
  input  logic [IW-1:0]    head,
  input  logic [OW-1:0]    occupancy,
  output logic [CW-1:0]    count
);

  logic [IW-1:0] idx;
  logic          run;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count = '0;
    run   = 1'b1;
    idx   = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head + IW'(i);
      if (run && (OW'(i) < occupancy) && ready[idx]) begin
        count = count + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_done_tracker.sv
// ROB done-bit tracker: allocation, write-back marking, in-order commit count.
// Define ROB_WB_BYPASS_EN to let same-cycle write-backs count toward commit_count.
module rob_done_tracker
  import rob_pkg::*;
#(
  parameter  int DEPTH    = ROB_DEPTH,
  parameter  int NUM_WB   = ROB_NUM_WB,
  parameter  int COMMIT_W = ROB_COMMIT_W,
  localparam int IW       = $clog2(DEPTH),
  localparam int CW       = $clog2(COMMIT_W + 1),
  localparam int OW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [IW-1:0]        alloc_idx,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB*IW-1:0] wb_idx,
  output logic [IW-1:0]        commit_idx,
  output logic [CW-1:0]        commit_count,
  input  logic [CW-1:0]        commit_pop,
  input  logic                 flush,
  output logic [OW-1:0]        occupancy,
  output logic                 empty
);

  logic [IW-1:0]    head, tail;
  logic [DEPTH-1:0] done, done_next, wb_set, ready;
  logic [IW-1:0]    wb_off;
  logic [CW-1:0]    pop_amt;
  logic             alloc_fire;

  assign alloc_ready = (occupancy != OW'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail;
  assign commit_idx  = head;
  assign empty       = (occupancy == '0);
  assign pop_amt     = (commit_pop > commit_count) ? commit_count : commit_pop;

  // Only write-backs landing inside [head, head+occupancy) are honoured.
  always_comb begin
    wb_set = '0;
    wb_off = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_off = wb_idx[k*IW +: IW] - head;
      if (wb_valid[k] && (OW'(wb_off) < occupancy)) begin
        wb_set[wb_idx[k*IW +: IW]] = 1'b1;
      end
    end
  end

  // The tail slot is never occupied here, so clearing it cannot lose a write-back.
  always_comb begin
    done_next = done | wb_set;
    if (alloc_fire) begin
      done_next[tail] = 1'b0;
    end
  end

`ifdef ROB_WB_BYPASS_EN
  assign ready = done | wb_set;
`else
  assign ready = done;
`endif

  rob_ready_scan #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W)
  ) u_scan (
    .ready     (ready),
    .head      (head),
    .occupancy (occupancy),
    .count     (commit_count)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      done      <= '0;
    end else begin
      head      <= head + IW'(pop_amt);
      tail      <= tail + IW'(alloc_fire);
      occupancy <= occupancy + OW'(alloc_fire) - OW'(pop_amt);
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_rob_done_tracker.sv
// Directed, table-driven bench for rob_done_tracker at default parameters.
module tb_rob_done_tracker;

  localparam int NUM_WB = 7;
  localparam int IW     = 5;
  localparam int CW     = 2;
  localparam int OW     = 6;
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk, rst;
  logic                 alloc_valid, alloc_ready;
  logic [IW-1:0]        alloc_idx, commit_idx;
  logic [NUM_WB-1:0]    wb_valid;
  logic [NUM_WB*IW-1:0] wb_idx;
  logic [CW-1:0]        commit_count, commit_pop;
  logic                 flush, empty;
  logic [OW-1:0]        occupancy;

  int errors = 0;
  int checks = 0;

  rob_done_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_idx    (alloc_idx),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .commit_idx   (commit_idx),
    .commit_count (commit_count),
    .commit_pop   (commit_pop),
    .flush        (flush),
    .occupancy    (occupancy),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                 a;
    logic [NUM_WB-1:0]    wv;
    logic [NUM_WB*IW-1:0] wi;
    logic [CW-1:0]        pop;
    logic                 fl;
    logic                 rdy;
    logic [IW-1:0]        aidx;
    logic [IW-1:0]        cidx;
    logic [CW-1:0]        cnt;
    logic [OW-1:0]        occ;
    logic                 emp;
  } vec_t;

  function automatic logic [NUM_WB*IW-1:0] wbp(input int port, input int idx);
    logic [NUM_WB*IW-1:0] r;
    r = '0;
    r[port*IW +: IW] = idx[IW-1:0];
    return r;
  endfunction

  function automatic vec_t mk(input logic a, input logic [NUM_WB-1:0] wv,
                              input logic [NUM_WB*IW-1:0] wi, input int pop, input logic fl,
                              input logic rdy, input int aidx, input int cidx,
                              input int cnt, input int occ, input logic emp);
    vec_t v;
    v.a = a;  v.wv = wv;  v.wi = wi;  v.pop = pop[CW-1:0];  v.fl = fl;
    v.rdy = rdy;  v.aidx = aidx[IW-1:0];  v.cidx = cidx[IW-1:0];
    v.cnt = cnt[CW-1:0];  v.occ = occ[OW-1:0];  v.emp = emp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    alloc_valid = v.a;
    wb_valid    = v.wv;
    wb_idx      = v.wi;
    commit_pop  = v.pop;
    flush       = v.fl;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #2;
    check({tag, ".alloc_ready"},  32'(alloc_ready),  32'(v.rdy));
    check({tag, ".alloc_idx"},    32'(alloc_idx),    32'(v.aidx));
    check({tag, ".commit_idx"},   32'(commit_idx),   32'(v.cidx));
    check({tag, ".commit_count"}, 32'(commit_count), 32'(v.cnt));
    check({tag, ".occupancy"},    32'(occupancy),    32'(v.occ));
    check({tag, ".empty"},        32'(empty),        32'(v.emp));
  endtask

  // Inputs-only step; expected fields unused.
  task automatic step(input logic a, input logic [NUM_WB-1:0] wv,
                      input logic [NUM_WB*IW-1:0] wi, input int pop, input logic fl);
    drive(mk(a, wv, wi, pop, fl, 0, 0, 0, 0, 0, 0));
  endtask

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;  alloc_valid = 1'b0;  wb_valid = '0;  wb_idx = '0;
    commit_pop = '0;  flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill to full from reset; the 33rd request is refused.
    for (int i = 0; i <= 32; i++)
      apply(mk(1, 0, 0, 0, 0, i < 32, i % 32, 0, 0, i, i == 0), $sformatf("fill[%0d]", i));

    // Full ROB: pop and alloc together, alloc only lands the cycle after.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 0), "full.idle");
    apply(mk(0, 7'b1, wbp(0, 0), 0, 0, 0, 0, 0, BYP ? 1 : 0, 32, 0), "full.wb0");
    apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 32, 0), "full.pop_alloc");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 31, 0), "full.alloc");
    apply(mk(1, 7'b100, wbp(2, 5), 1, 1, 0, 1, 1, 0, 32, 0), "full.flush");

    // Out-of-order completion, pop clamping, multi-port hits, same-cycle alloc+wb.
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 2, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 3, 0);
    tbl[4]  = mk(0, 7'b1, wbp(0, 1), 0, 0, 1, 4, 0, 0, 4, 0);
    tbl[5]  = mk(0, 7'b1, wbp(0, 0), 0, 0, 1, 4, 0, BYP ? 2 : 0, 4, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 4, 0, 2, 4, 0);
    tbl[7]  = mk(0, 0, 0, 3, 0, 1, 4, 0, 2, 4, 0);
    tbl[8]  = mk(0, 0, 0, 2, 0, 1, 4, 2, 0, 2, 0);
    tbl[9]  = mk(0, 7'b1000001, wbp(0, 2) | wbp(6, 2), 0, 0, 1, 4, 2, BYP ? 1 : 0, 2, 0);
    tbl[10] = mk(0, 7'b1000000, wbp(6, 3), 0, 0, 1, 4, 2, BYP ? 2 : 1, 2, 0);
    tbl[11] = mk(0, 0, 0, 2, 0, 1, 4, 2, 2, 2, 0);
    tbl[12] = mk(1, 7'b1, wbp(0, 4), 0, 0, 1, 4, 4, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 5, 4, 0, 1, 0);
    tbl[14] = mk(0, 7'b1000, wbp(3, 4), 0, 0, 1, 5, 4, BYP ? 1 : 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 1, 5, 4, 1, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 1);
    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Write-back to unoccupied entry 9 must not survive its later allocation.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      apply(mk(1, 0, 0, 0, 0, 1, i, 0, 0, i, i == 0), $sformatf("u9.alloc[%0d]", i));
    apply(mk(0, 7'b1111, wbp(0, 9) | wbp(1, 0) | wbp(2, 1) | wbp(3, 2), 0, 0,
             1, 3, 0, BYP ? 2 : 0, 3, 0), "u9.wb");
    for (int i = 3; i <= 9; i++)
      apply(mk(1, 0, 0, 0, 0, 1, i, 0, 2, i, 0), $sformatf("u9.alloc[%0d]", i));
    apply(mk(0, 7'b111111, wbp(0, 3) | wbp(1, 4) | wbp(2, 5) | wbp(3, 6) | wbp(4, 7) | wbp(5, 8),
             0, 0, 1, 10, 0, 2, 10, 0), "u9.wb3to8");
    for (int j = 0; j < 4; j++)
      apply(mk(0, 0, 0, 2, 0, 1, 10, 2 * j, 2, 10 - 2 * j, 0), $sformatf("u9.pop[%0d]", j));
    apply(mk(0, 0, 0, 2, 0, 1, 10, 8, 1, 2, 0), "u9.pop_last");
    apply(mk(0, 0, 0, 0, 0, 1, 10, 9, 0, 1, 0), "u9.stall");

    // Move head to 30, then retire across the wrap point.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++)
      step(1, (i > 0) ? 7'b1 : 7'b0, wbp(0, i - 1), 0, 0);
    step(0, 7'b1, wbp(0, 29), 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0);
    step(1, 7'b1, wbp(0, 30), 0, 0);
    step(1, 7'b1, wbp(0, 31), 0, 0);
    step(0, 7'b1, wbp(0, 0), 0, 0);
    apply(mk(0, 0, 0, 2, 0, 1, 1, 30, 2, 3, 0), "wrap.pop");
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0), "wrap.after");

    // Flush at occupancy 5 with concurrent alloc, wb and pop.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    apply(mk(1, 7'b10, wbp(1, 1), 1, 1, 1, 5, 0, BYP ? 2 : 1, 5, 0), "flush5.req");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "flush5.after");

    // Reset wins over an in-flight commit and allocation.
    step(1, 0, 0, 0, 0);
    step(1, 7'b1, wbp(0, 0), 0, 0);
    step(0, 7'b1, wbp(0, 1), 0, 0);
    @(negedge clk);
    rst = 1'b1;  alloc_valid = 1'b1;  commit_pop = 2'd2;  wb_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;  alloc_valid = 1'b0;  commit_pop = '0;
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_done_tracker.md
ROB_DONE_TRACKER -- requirements
Module: rob_done_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of ROB entries (power of 2, >=4).
REQ-002 SHALL have parameter NUM_WB, default 7, number of write-back (done-broadcast) ports.
REQ-003 SHALL have parameter COMMIT_W, default 2, maximum entries retired per cycle (1..4).
REQ-004 SHALL derive IW=$clog2(DEPTH), CW=$clog2(COMMIT_W+1), OW=$clog2(DEPTH+1).
REQ-005 SHALL use clock clk and reset rst, synchronous, active-high: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-006 SHALL have: alloc_valid input 1 request to allocate the tail entry.
REQ-007 SHALL have: alloc_ready output 1 high when not full.
REQ-008 SHALL have: alloc_idx output IW current tail index.
REQ-009 SHALL have: wb_valid input NUM_WB per-port done strobe; wb_idx input NUM_WB*IW per-port entry index (port k at bits [k*IW +: IW]).
REQ-010 SHALL have: commit_idx output IW current head index; commit_count output CW number of contiguous done entries from head.
REQ-011 SHALL have: commit_pop input CW entries retired this cycle.
REQ-012 SHALL have: flush input 1 discard all entries; occupancy output OW entry count; empty output 1.

Function
REQ-013 SHALL keep head, tail (IW bits, natural wrap DEPTH-1 -> 0), occupancy counter, and a DEPTH-bit done vector.
REQ-014 alloc_ready SHALL equal (occupancy != DEPTH), independent of commit_pop (no comb path pop->ready).
REQ-015 On alloc_valid && alloc_ready: done[tail] <= 0, tail <= tail+1; alloc_valid while !alloc_ready SHALL be ignored.
REQ-016 On wb_valid[k] with wb_idx[k] occupied (within [head, head+occupancy) modulo DEPTH): done[wb_idx[k]] <= 1; writes to unoccupied entries SHALL be ignored; multiple ports hitting one index SHALL be legal.
REQ-017 Entry i ready SHALL mean done[i] OR (any wb_valid[k] with wb_idx[k]==i, when bypass enabled, REQ-027).
REQ-018 commit_count SHALL be the count of consecutive ready entries starting at head, capped at min(COMMIT_W, occupancy); purely combinational, same cycle.
REQ-019 Retirement: head <= head+commit_pop; commit_pop > commit_count SHALL be clamped to commit_count.
REQ-020 occupancy <= occupancy + alloc_fire - pop_clamped; simultaneous alloc and pop SHALL both take effect.
REQ-021 Write-back to an entry allocated the same cycle SHALL be ignored (entry unoccupied at sample time); allocation clears it.
REQ-022 flush SHALL override alloc, wb and pop: head, tail, occupancy <= 0, done <= 0, next cycle.
REQ-023 empty SHALL equal (occupancy==0); commit_count SHALL be 0 when empty.

Reset
REQ-024 On rst: head=tail=0, occupancy=0, done=0; hence alloc_ready=1, alloc_idx=0, commit_idx=0, commit_count=0, occupancy=0, empty=1.
REQ-025 rst SHALL take priority over flush and all other inputs, including mid-commit.

Configuration
REQ-026 Macro ROB_WB_BYPASS_EN SHALL select write-back bypass.
REQ-027 Defined: same-cycle write-back counts as ready in REQ-018 (zero-cycle wb->commit). Undefined: only registered done bits count (one-cycle wb->commit); all else identical.

Structure
REQ-028 Package rob_pkg SHALL hold ROB_DEPTH=32, ROB_NUM_WB=7, ROB_COMMIT_W=2 defaults and typedef rob_idx_t (logic [$clog2(ROB_DEPTH)-1:0]).
REQ-029 Contiguous-ready prefix count SHALL be a sub-module rob_ready_scan (combinational; inputs ready vector, head, occupancy; output count).

Verification
REQ-030 Reset then 32 allocs: alloc_idx 0..31, after 32nd alloc_ready=0, occupancy=32; 33rd alloc ignored.
REQ-031 Alloc 4; wb idx 1 then idx 0 next cycle: commit_count 0 until idx0 done, then 2 (bypass: same cycle as idx0 wb; no bypass: one cycle later).
REQ-032 head=30, entries 30,31,0 done, COMMIT_W=2, commit_pop=2: commit_idx becomes 0, commit_count=1 next cycle (wrap).
REQ-033 Full ROB, commit_pop=1 and alloc_valid same cycle: alloc ignored (alloc_ready=0), occupancy=31; next cycle alloc accepted, occupancy=32.
REQ-034 wb to unoccupied idx 9 with occupancy=3 at head 0, then alloc up to idx 9: done[9]=0, commit stalls at 9.
REQ-035 flush with occupancy=5, concurrent wb and alloc: next cycle occupancy=0, empty=1, commit_idx=alloc_idx=0, commit_count=0.
